// File: rtl/opc7intc.sv
// rtl/opc7intc.sv - OPC-7 prioritised, vectored interrupt controller
//
// Purpose: aggregates NCHAN interrupt lines into one active-low request with
// fixed priority (channel 0 highest), per-channel edge/level mode, nested
// in-service tracking and a per-channel vector latched at acknowledge.
//
// Ports:
//   i_clk         system clock
//   i_reset       asynchronous, active-high reset
//   i_clken       clock enable; all state advances only when high
//   i_irq_in      raw interrupt lines (asynchronous, active-high)
//   i_sel         I/O access strobe
//   i_rnw         1 = read, 0 = write
//   i_addr        register index
//   i_din         write data
//   o_dout        registered read data
//   o_int_b       active-low interrupt request to the CPU
//   i_int_ack     one-cycle acknowledge pulse from the CPU
//   o_int_vector  vector address latched at acknowledge
module opc7intc #(
  parameter int          NCHAN         = 8,
  parameter logic [19:0] VECTOR_BASE   = 20'h00002,
  parameter int          VECTOR_STRIDE = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clken,
  input  logic [NCHAN-1:0] i_irq_in,
  input  logic             i_sel,
  input  logic             i_rnw,
  input  logic [2:0]       i_addr,
  input  logic [31:0]      i_din,
  output logic [31:0]      o_dout,
  output logic             o_int_b,
  input  logic             i_int_ack,
  output logic [19:0]      o_int_vector
);

  localparam logic [2:0] A_STATUS  = 3'd0;
  localparam logic [2:0] A_ENABLE  = 3'd1;
  localparam logic [2:0] A_MODE    = 3'd2;
  localparam logic [2:0] A_CLEAR   = 3'd3;
  localparam logic [2:0] A_INSVC   = 3'd4;
  localparam logic [2:0] A_EOI     = 3'd5;
  localparam logic [2:0] A_CURRENT = 3'd6;
  localparam logic [2:0] A_SWI     = 3'd7;

  // Vector handed out when nothing eligible is being acknowledged.
  localparam logic [19:0] SPURIOUS_VECTOR =
    20'(VECTOR_BASE + 20'(NCHAN) * 20'(VECTOR_STRIDE));

  typedef enum logic {ST_IDLE, ST_REQ} st_t;

  st_t              r_st;
  st_t              w_st_next;
  logic [NCHAN-1:0] r_sync1, r_sync2, r_sync3;
  // Edge channels: the pending bit itself. Level channels: the sticky SWI bit.
  logic [NCHAN-1:0] r_pend;
  logic [NCHAN-1:0] r_en, r_mode, r_insvc;
  logic             r_cur_valid;
  logic [3:0]       r_cur_idx;
  logic [31:0]      r_dout;
  logic [19:0]      r_vector;

  logic             w_wr, w_rd, w_ack, w_eoi;
  logic [NCHAN-1:0] w_din_lo, w_pend, w_req, w_edge, w_set, w_clr;
  logic [NCHAN-1:0] w_grant_mask, w_eoi_mask;
  logic             w_cand_any, w_isv_any, w_eligible, w_grant;
  logic [3:0]       w_cand_idx, w_isv_idx;
  logic [31:0]      w_rdata;
  logic             w_unused_din;

  assign w_din_lo     = i_din[NCHAN-1:0];
  assign w_unused_din = ^i_din[31:NCHAN];

  // Bus and acknowledge are ignored while the clock enable is low.
  assign w_wr  = i_clken & i_sel & ~i_rnw;
  assign w_rd  = i_clken & i_sel & i_rnw;
  assign w_ack = i_clken & i_int_ack;
  assign w_eoi = w_wr && (i_addr == A_EOI);

  assign w_pend = (r_mode & r_pend) | (~r_mode & (r_sync2 | r_pend));
  assign w_req  = w_pend & r_en;
  assign w_edge = r_sync2 & ~r_sync3 & r_mode;

  // Lowest-index requesting channel and lowest in-service channel.
  always_comb begin
    w_cand_any = 1'b0;
    w_cand_idx = 4'd0;
    w_isv_any  = 1'b0;
    w_isv_idx  = 4'd0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_cand_any = 1'b1;
        w_cand_idx = 4'(i);
      end
      if (r_insvc[i]) begin
        w_isv_any = 1'b1;
        w_isv_idx = 4'(i);
      end
    end
  end

  // A candidate may only preempt strictly lower-priority work in service.
  assign w_eligible = w_cand_any & (~w_isv_any | (w_cand_idx < w_isv_idx));
  assign w_grant    = w_ack & (r_st == ST_REQ) & w_eligible;

  always_comb begin
    w_grant_mask = '0;
    w_eoi_mask   = '0;
    for (int i = 0; i < NCHAN; i++) begin
      w_grant_mask[i] = w_grant & (w_cand_idx == 4'(i));
      w_eoi_mask[i]   = w_eoi & w_isv_any & (w_isv_idx == 4'(i));
    end
  end

  assign w_set = w_edge | ((w_wr && (i_addr == A_SWI)) ? w_din_lo : '0);
  assign w_clr = w_grant_mask | ((w_wr && (i_addr == A_CLEAR)) ? w_din_lo : '0);

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_st <= ST_IDLE;
    end else if (i_clken) begin
      r_st <= w_st_next;
    end
  end

  // Next-state logic (i_clken gating lives in the state register)
  always_comb begin
    w_st_next = r_st;
    case (r_st)
      ST_IDLE: if (w_eligible) w_st_next = ST_REQ;
      ST_REQ:  if (i_int_ack || !w_eligible) w_st_next = ST_IDLE;
      default: w_st_next = ST_IDLE;
    endcase
  end

  // Output logic: decoded straight from the state so reset releases int_b at once.
  always_comb begin
    o_int_b = 1'b1;
    if (r_st == ST_REQ) o_int_b = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_sync3     <= '0;
      r_pend      <= '0;
      r_en        <= '0;
      r_mode      <= '0;
      r_insvc     <= '0;
      r_cur_valid <= 1'b0;
      r_cur_idx   <= 4'd0;
      r_vector    <= VECTOR_BASE;
      r_dout      <= 32'd0;
    end else if (i_clken) begin
      r_sync1 <= i_irq_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      // Set has priority over clear in the same cycle.
      r_pend  <= (r_pend & ~w_clr) | w_set;
      r_insvc <= (r_insvc & ~w_eoi_mask) | w_grant_mask;
      if (w_wr && (i_addr == A_ENABLE)) r_en   <= w_din_lo;
      if (w_wr && (i_addr == A_MODE))   r_mode <= w_din_lo;
      if (w_ack) begin
        r_cur_valid <= w_grant;
        if (w_grant) begin
          r_cur_idx <= w_cand_idx;
          r_vector  <= 20'(VECTOR_BASE + 20'(w_cand_idx) * 20'(VECTOR_STRIDE));
        end else begin
          r_vector  <= SPURIOUS_VECTOR;
        end
      end
      if (w_rd) r_dout <= w_rdata;
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    case (i_addr)
      A_STATUS:  w_rdata = 32'(w_pend);
      A_ENABLE:  w_rdata = 32'(r_en);
      A_MODE:    w_rdata = 32'(r_mode);
      A_INSVC:   w_rdata = 32'(r_insvc);
      A_CURRENT: w_rdata = {r_cur_valid, 27'd0, r_cur_idx};
      default:   w_rdata = 32'd0;
    endcase
  end

  assign o_dout       = r_dout;
  assign o_int_vector = r_vector;

endmodule

// File: tb/tb_opc7intc.sv
// tb/tb_opc7intc.sv - directed self-checking bench for opc7intc
module tb_opc7intc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clken = 1'b1;
  logic [7:0]  irq = 8'd0;
  logic        sel = 1'b0;
  logic        rnw = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [31:0] din = 32'd0;
  logic [31:0] dout;
  logic        int_b;
  logic        int_ack = 1'b0;
  logic [19:0] int_vector;

  int checks = 0;
  int errors = 0;

  opc7intc #(.NCHAN(8), .VECTOR_BASE(20'h00002), .VECTOR_STRIDE(2)) dut (
    .i_clk(clk), .i_reset(reset), .i_clken(clken), .i_irq_in(irq),
    .i_sel(sel), .i_rnw(rnw), .i_addr(addr), .i_din(din), .o_dout(dout),
    .o_int_b(int_b), .i_int_ack(int_ack), .o_int_vector(int_vector)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    sel = 1'b1; rnw = 1'b0; addr = a; din = d;
    cyc();
    sel = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    sel = 1'b1; rnw = 1'b1; addr = a;
    cyc();
    sel = 1'b0; rnw = 1'b0;
    d = dout;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    cyc();
    int_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    wr(3'd1, 32'h01);
    wr(3'd7, 32'h01);
    cyc();
    checks++; if (int_b !== 1'b0) begin errors++; $display("FAIL rst_req int_b got %b want 0", int_b); end
    #2 reset = 1'b1;
    #1;
    checks++; if (int_b !== 1'b1) begin errors++; $display("FAIL rst_async int_b got %b want 1", int_b); end
    reset = 1'b0;
    cyc();
    checks++; if (int_vector !== 20'h00002) begin errors++; $display("FAIL rst_vec got %h want 00002", int_vector); end
    checks++; if (dout !== 32'd0) begin errors++; $display("FAIL rst_dout got %h want 0", dout); end
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_reg%0d got %h want 0", a, d); end
    end
  endtask

  task automatic test_single_edge();
    logic [31:0] d;
    wr(3'd1, 32'h04);
    wr(3'd2, 32'h04);
    irq[2] = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      checks++; if (int_b !== 1'b1) begin errors++; $display("FAIL edge_lat%0d int_b got %b want 1", c, int_b); end
    end
    cyc();
    checks++; if (int_b !== 1'b0) begin errors++; $display("FAIL edge_lat4 int_b got %b want 0", int_b); end
    irq[2] = 1'b0;
    ack();
    checks++; if (int_vector !== 20'h00006) begin errors++; $display("FAIL edge_vec got %h want 00006", int_vector); end
    checks++; if (int_b !== 1'b1) begin errors++; $display("FAIL edge_intb_after_ack got %b want 1", int_b); end
    rd(3'd4, d);
    checks++; if (d !== 32'h04) begin errors++; $display("FAIL edge_insvc got %h want 04", d); end
    rd(3'd0, d);
    checks++; if (d !== 32'h00) begin errors++; $display("FAIL edge_status got %h want 00", d); end
    rd(3'd6, d);
    checks++; if (d !== 32'h80000002) begin errors++; $display("FAIL edge_current got %h want 80000002", d); end
    wr(3'd5, 32'h0);
    rd(3'd4, d);
    checks++; if (d !== 32'h00) begin errors++; $display("FAIL edge_eoi got %h want 00", d); end
  endtask

  task automatic test_priority_nesting();
    logic [31:0] d;
    wr(3'd1, 32'h22);
    wr(3'd2, 32'h22);
    irq[5] = 1'b1;
    repeat (4) cyc();
    checks++; if (int_b !== 1'b0) begin errors++; $display("FAIL prio_ch5_req int_b got %b want 0", int_b); end
    irq[5] = 1'b0;
    ack();
    checks++; if (int_vector !== 20'h0000C) begin errors++; $display("FAIL prio_ch5_vec got %h want 0000c", int_vector); end
    repeat (3) cyc();
    irq = 8'h22;
    repeat (4) cyc();
    checks++; if (int_b !== 1'b0) begin errors++; $display("FAIL prio_nest_req int_b got %b want 0", int_b); end
    irq = 8'h00;
    ack();
    checks++; if (int_vector !== 20'h00004) begin errors++; $display("FAIL prio_nest_vec got %h want 00004", int_vector); end
    rd(3'd4, d);
    checks++; if (d !== 32'h22) begin errors++; $display("FAIL prio_insvc got %h want 22", d); end
    rd(3'd0, d);
    checks++; if (d !== 32'h20) begin errors++; $display("FAIL prio_status got %h want 20", d); end
    repeat (3) cyc();
    checks++; if (int_b !== 1'b1) begin errors++; $display("FAIL prio_masked int_b got %b want 1", int_b); end
    wr(3'd5, 32'h0);
    cyc();
    checks++; if (int_b !== 1'b1) begin errors++; $display("FAIL prio_eoi1 int_b got %b want 1", int_b); end
    wr(3'd5, 32'h0);
    checks++; if (int_b !== 1'b1) begin errors++; $display("FAIL prio_eoi2_same int_b got %b want 1", int_b); end
    cyc();
    checks++; if (int_b !== 1'b0) begin errors++; $display("FAIL prio_rereq int_b got %b want 0", int_b); end
    ack();
    checks++; if (int_vector !== 20'h0000C) begin errors++; $display("FAIL prio_ch5_again got %h want 0000c", int_vector); end
    wr(3'd5, 32'h0);
  endtask

  task automatic test_level();
    logic [31:0] d;
    wr(3'd1, 32'h08);
    wr(3'd2, 32'h00);
    irq[3] = 1'b1;
    repeat (3) cyc();
    checks++; if (int_b !== 1'b0) begin errors++; $display("FAIL lvl_req int_b got %b want 0", int_b); end
    wr(3'd3, 32'h08);
    rd(3'd0, d);
    checks++; if (d !== 32'h08) begin errors++; $display("FAIL lvl_status got %h want 08", d); end
    ack();
    checks++; if (int_vector !== 20'h00008) begin errors++; $display("FAIL lvl_vec got %h want 00008", int_vector); end
    repeat (2) cyc();
    checks++; if (int_b !== 1'b1) begin errors++; $display("FAIL lvl_insvc_mask int_b got %b want 1", int_b); end
    wr(3'd5, 32'h0);
    cyc();
    checks++; if (int_b !== 1'b0) begin errors++; $display("FAIL lvl_reassert int_b got %b want 0", int_b); end
    irq[3] = 1'b0;
    repeat (3) cyc();
    checks++; if (int_b !== 1'b1) begin errors++; $display("FAIL lvl_drop int_b got %b want 1", int_b); end
  endtask

  task automatic test_withdraw_spurious();
    logic [31:0] d;
    wr(3'd1, 32'h01);
    wr(3'd7, 32'h01);
    cyc();
    checks++; if (int_b !== 1'b0) begin errors++; $display("FAIL wd_req int_b got %b want 0", int_b); end
    wr(3'd1, 32'h00);
    checks++; if (int_b !== 1'b0) begin errors++; $display("FAIL wd_same int_b got %b want 0", int_b); end
    cyc();
    checks++; if (int_b !== 1'b1) begin errors++; $display("FAIL wd_idle int_b got %b want 1", int_b); end
    ack();
    checks++; if (int_vector !== 20'h00012) begin errors++; $display("FAIL wd_spur_vec got %h want 00012", int_vector); end
    rd(3'd6, d);
    checks++; if (d[31] !== 1'b0) begin errors++; $display("FAIL wd_cur_valid got %b want 0", d[31]); end
    rd(3'd4, d);
    checks++; if (d !== 32'h00) begin errors++; $display("FAIL wd_insvc got %h want 00", d); end
    rd(3'd0, d);
    checks++; if (d !== 32'h01) begin errors++; $display("FAIL wd_status got %h want 01", d); end
    wr(3'd3, 32'h01);
  endtask

  task automatic test_clken_swi();
    logic [31:0] d;
    wr(3'd1, 32'h01);
    wr(3'd2, 32'h01);
    wr(3'd7, 32'h01);
    clken = 1'b0;
    cyc();
    checks++; if (int_b !== 1'b1) begin errors++; $display("FAIL ce_hold int_b got %b want 1", int_b); end
    clken = 1'b1;
    cyc();
    checks++; if (int_b !== 1'b0) begin errors++; $display("FAIL ce_req int_b got %b want 0", int_b); end
    clken = 1'b0;
    int_ack = 1'b1;
    cyc();
    int_ack = 1'b0;
    checks++; if (int_b !== 1'b0) begin errors++; $display("FAIL ce_ack_ignored int_b got %b want 0", int_b); end
    checks++; if (int_vector !== 20'h00012) begin errors++; $display("FAIL ce_vec_hold got %h want 00012", int_vector); end
    wr(3'd1, 32'hFF);
    clken = 1'b1;
    ack();
    checks++; if (int_vector !== 20'h00002) begin errors++; $display("FAIL ce_vec got %h want 00002", int_vector); end
    rd(3'd1, d);
    checks++; if (d !== 32'h01) begin errors++; $display("FAIL ce_wr_ignored got %h want 01", d); end
    rd(3'd4, d);
    checks++; if (d !== 32'h01) begin errors++; $display("FAIL ce_insvc got %h want 01", d); end
    wr(3'd5, 32'h0);
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_priority_nesting();
    test_level();
    test_withdraw_spurious();
    test_clken_swi();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
